seq_adder_nbyte: RTL and testbench
==================================

SEQ_ADDER_NBYTE -- requirements
Module: seq_adder_nbyte

Interface
REQ-001 SHALL have parameter NBYTES, default 4, the number of 8-bit bytes per operand; legal values are 2 and above.
REQ-002 SHALL have parameter W, derived as 8*NBYTES, the operand/result width; it is not overridable.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit, a request to begin one addition; sampled only in IDLE.
REQ-006 SHALL have port a, input, W bits, operand A; captured on the accepted start.
REQ-007 SHALL have port b, input, W bits, operand B; captured on the accepted start.
REQ-008 SHALL have port cin, input, 1 bit, the carry-in into byte 0; captured on the accepted start.
REQ-009 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-010 SHALL have port done, output, 1 bit, a one-cycle pulse marking that the result is valid.
REQ-011 SHALL have port soma, output, W bits, the registered sum.
REQ-012 SHALL have port cout, output, 1 bit, the registered carry-out of the top byte.
REQ-013 SHALL have port ovf, output, 1 bit, the registered signed overflow of the full-width sum.

Function
REQ-014 SHALL use exactly one 8-bit full-adder instance and time-share it, least significant byte first, one byte per cycle.
REQ-015 SHALL implement an FSM with states IDLE, ADD and DONE.
REQ-016 SHALL, in IDLE with start=1 at edge E0, latch a, b and cin, clear the byte index and the internal result register, and enter ADD.
REQ-017 SHALL, in ADD, feed the adder byte[idx] of latched A, byte[idx] of latched B, and the carry register; the carry register holds cin when idx=0.
REQ-018 SHALL, at each ADD edge, write the adder sum into result byte[idx], load the carry register from the adder carry-out, and increment idx.
REQ-019 SHALL, at the edge where idx=NBYTES-1, copy the full result to soma, the adder carry-out to cout and the adder overflow to ovf, then enter DONE.
REQ-020 SHALL hold done=1 for exactly the one DONE cycle, then return to IDLE unconditionally.
REQ-021 SHALL assert done NBYTES cycles after the start-sampling edge (4 cycles at default NBYTES).
REQ-022 SHALL ignore start while busy=1, including in the DONE cycle; a start held high continuously is accepted again in the first IDLE cycle.
REQ-023 SHALL hold soma, cout and ovf at the last completed result until the next completion; no partial results are ever visible on them.
REQ-024 SHALL compute ovf from the top byte only: carry into bit W-1 XOR carry out of bit W-1.
REQ-025 SHALL keep operand inputs changing during ADD from affecting the result.

Reset
REQ-026 SHALL, when rst_n=0 at a clock edge, force state=IDLE, idx=0, carry=0, result=0, soma=0, cout=0, ovf=0, done=0 and busy=0.
REQ-027 SHALL, on reset mid-operation, abandon the operation and produce no done pulse; a start in the first cycle after rst_n returns high is accepted.
REQ-028 SHALL let rst_n take priority over start at the same edge.

Structure
REQ-029 SHALL place the FSM state encoding (IDLE/ADD/DONE), the byte width constant 8 and the default NBYTES in a shared package/include used by the RTL and the bench.
REQ-030 SHALL instantiate the existing full_adder_8bit as its only sub-module; no other adder logic is permitted.

Verification
REQ-031 SHALL cover reset: rst_n=0 for 2 cycles -> busy=0, done=0, soma=0, cout=0, ovf=0.
REQ-032 SHALL cover carry ripple: a=0x000000FF, b=0x00000001, cin=0 -> done 4 cycles after start, soma=0x00000100, cout=0, ovf=0.
REQ-033 SHALL cover full wrap: a=0xFFFFFFFF, b=0x00000001, cin=0 -> soma=0x00000000, cout=1, ovf=0.
REQ-034 SHALL cover signed overflow via cin: a=0x7FFFFFFF, b=0x00000000, cin=1 -> soma=0x80000000, cout=0, ovf=1.
REQ-035 SHALL cover ignored start: a second start with a=b=0x11111111 two cycles into an operation -> first result unchanged, exactly one done pulse.
REQ-036 SHALL cover reset mid-operation: rst_n=0 after byte 1 -> no done, outputs 0; a following start with a=1, b=2 -> soma=0x00000003.

Source files
------------

// File: rtl/seq_adder_nbyte_pkg.sv
// rtl/seq_adder_nbyte_pkg.sv - shared constants for the byte-serial adder
// Holds the byte width, the default operand size in bytes and the FSM
// state encoding, so the RTL and the bench agree on them.
package seq_adder_nbyte_pkg;

   localparam int BYTE_W         = 8;
   localparam int NBYTES_DEFAULT = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADD  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/full_adder_8bit.sv
// rtl/full_adder_8bit.sv - combinational 8-bit adder with carry and signed overflow
// Ports:
//   a, b  : byte operands
//   cin   : carry into bit 0
//   sum   : byte sum
//   cout  : carry out of bit 7
//   ovf   : carry into bit 7 XOR carry out of bit 7 (signed overflow of this byte)
module full_adder_8bit
   import seq_adder_nbyte_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              cin,
   output logic [BYTE_W-1:0] sum,
   output logic              cout,
   output logic              ovf
);

   // Split at the top bit so the carry into the MSB is directly available.
   logic [BYTE_W-1:0] low;
   logic [1:0]        top;

   assign low  = {1'b0, a[BYTE_W-2:0]} + {1'b0, b[BYTE_W-2:0]} + {{(BYTE_W-1){1'b0}}, cin};
   assign top  = {1'b0, a[BYTE_W-1]} + {1'b0, b[BYTE_W-1]} + {1'b0, low[BYTE_W-1]};
   assign sum  = {top[0], low[BYTE_W-2:0]};
   assign cout = top[1];
   assign ovf  = low[BYTE_W-1] ^ top[1];

endmodule

// File: rtl/seq_adder_nbyte.sv
// rtl/seq_adder_nbyte.sv - byte-serial NBYTES*8-bit adder sharing one 8-bit adder
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   start      : begin one addition (sampled only while idle)
//   a, b, cin  : operands and carry-in, captured when start is accepted
//   busy       : high whenever an operation is in progress (state not IDLE)
//   done       : one-cycle pulse when soma/cout/ovf hold a new result
//   soma       : registered sum, updated only on completion
//   cout, ovf  : registered carry-out and signed overflow of the full sum
module seq_adder_nbyte
   import seq_adder_nbyte_pkg::*;
#(
   parameter  int NBYTES = NBYTES_DEFAULT,
   localparam int W      = BYTE_W * NBYTES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] soma,
   output logic         cout,
   output logic         ovf
);

   localparam int              IDXW     = $clog2(NBYTES);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

   logic [1:0]        state;
   logic [IDXW-1:0]   idx;
   logic              carry;
   logic [W-1:0]      a_lat;
   logic [W-1:0]      b_lat;
   logic [W-1:0]      result;
   logic [W-1:0]      result_next;
   logic [BYTE_W-1:0] fa_a;
   logic [BYTE_W-1:0] fa_b;
   logic [BYTE_W-1:0] fa_sum;
   logic              fa_cout;
   logic              fa_ovf;

   assign fa_a = a_lat[idx*BYTE_W +: BYTE_W];
   assign fa_b = b_lat[idx*BYTE_W +: BYTE_W];

   full_adder_8bit u_fa (
      .a    (fa_a),
      .b    (fa_b),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout),
      .ovf  (fa_ovf)
   );

   // Result with the current byte merged in; on the last byte this is the
   // complete sum, copied straight to soma so no partial value is ever exposed.
   always_comb begin
      result_next = result;
      result_next[idx*BYTE_W +: BYTE_W] = fa_sum;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         idx    <= '0;
         carry  <= 1'b0;
         result <= '0;
         a_lat  <= '0;
         b_lat  <= '0;
         soma   <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_lat  <= a;
                  b_lat  <= b;
                  carry  <= cin;
                  idx    <= '0;
                  result <= '0;
                  state  <= ST_ADD;
               end
            end
            ST_ADD: begin
               result <= result_next;
               carry  <= fa_cout;
               idx    <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  soma  <= result_next;
                  cout  <= fa_cout;
                  ovf   <= fa_ovf;
                  state <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_adder_nbyte.sv
// tb/tb_seq_adder_nbyte.sv - scoreboard bench for seq_adder_nbyte
module tb_seq_adder_nbyte;
   import seq_adder_nbyte_pkg::*;

   localparam int NB = NBYTES_DEFAULT;
   localparam int W  = BYTE_W * NB;

   typedef struct {
      logic [W-1:0] soma;
      logic         cout;
      logic         ovf;
      int           edge_no;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         cin   = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] soma;
   logic         cout;
   logic         ovf;

   int cyc    = 0;
   int n_chk  = 0;
   int n_pass = 0;
   int n_done = 0;

   logic [W-1:0] last_soma = '0;
   logic         last_cout = 1'b0;
   logic         last_ovf  = 1'b0;

   seq_adder_nbyte #(.NBYTES(NB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .soma  (soma),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
   endtask

   // Reference: plain arithmetic on the full-width values.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic c, input int e);
      exp_t         r;
      logic [W:0]   s;
      longint       sv;
      s      = {1'b0, x} + {1'b0, y} + (W+1)'(c);
      sv     = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
      r.soma = s[W-1:0];
      r.cout = s[W];
      r.ovf  = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      r.edge_no = e;
      return r;
   endfunction

   // Monitor: every done pops one expectation; otherwise outputs must hold.
   always @(negedge clk) begin
      if (rst_n) begin
         if (done) begin
            n_done++;
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               mon_e = sb.pop_front();
               chk("soma", soma, mon_e.soma);
               chk("cout", W'(cout), W'(mon_e.cout));
               chk("ovf", W'(ovf), W'(mon_e.ovf));
               chk("latency", W'(cyc), W'(mon_e.edge_no + NB));
               last_soma = mon_e.soma;
               last_cout = mon_e.cout;
               last_ovf  = mon_e.ovf;
            end
         end else begin
            chk("hold_soma", soma, last_soma);
            chk("hold_flags", W'({cout, ovf}), W'({last_cout, last_ovf}));
         end
      end
   end

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (busy) chk("idle_timeout", W'(busy), 0);
   endtask

   // Issue one start at a negedge; operands are scrambled after acceptance.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
      wait_idle();
      start = 1'b1;
      a     = ta;
      b     = tb_;
      cin   = tc;
      sb.push_back(model(ta, tb_, tc, cyc + 1));
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      cin   = 1'($urandom);
      @(negedge clk);
      wait_idle();
   endtask

   initial begin
      int snap;
      int e2;
      int t;

      // Reset held two cycles, with start asserted to show reset wins.
      @(negedge clk);
      rst_n = 1'b0;
      start = 1'b1;
      a     = 32'h1234_5678;
      b     = 32'h0000_0001;
      repeat (2) @(negedge clk);
      chk("rst_busy", W'(busy), 0);
      chk("rst_done", W'(done), 0);
      chk("rst_soma", soma, 0);
      chk("rst_cout", W'(cout), 0);
      chk("rst_ovf", W'(ovf), 0);
      start = 1'b0;
      rst_n = 1'b1;

      // Directed corner cases.
      do_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
      do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      do_op(32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
      do_op(32'h8000_0000, 32'h8000_0000, 1'b0);

      // Start issued two cycles into an operation is ignored.
      wait_idle();
      snap  = n_done;
      start = 1'b1;
      a     = 32'h0000_00FF;
      b     = 32'h0000_0001;
      cin   = 1'b0;
      sb.push_back(model(32'h0000_00FF, 32'h0000_0001, 1'b0, cyc + 1));
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      a     = 32'h1111_1111;
      b     = 32'h1111_1111;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (4) @(negedge clk);
      chk("one_done", W'(n_done - snap), 1);

      // Start held high: accepted again in the first IDLE cycle after DONE.
      wait_idle();
      start = 1'b1;
      a     = $urandom;
      b     = $urandom;
      cin   = 1'b1;
      e2    = cyc + 1 + NB + 2;
      sb.push_back(model(a, b, cin, cyc + 1));
      sb.push_back(model(a, b, cin, e2));
      t = 0;
      while (cyc < e2 && t < 40) begin
         @(negedge clk);
         t++;
      end
      start = 1'b0;
      chk("reaccept_busy", W'(busy), 1);
      wait_idle();

      // Reset after byte 1 abandons the operation.
      wait_idle();
      snap  = n_done;
      start = 1'b1;
      a     = 32'hAAAA_5555;
      b     = 32'h5555_AAAA;
      cin   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      last_soma = '0;
      last_cout = 1'b0;
      last_ovf  = 1'b0;
      @(negedge clk);
      chk("midrst_busy", W'(busy), 0);
      chk("midrst_soma", soma, 0);
      chk("midrst_flags", W'({cout, ovf, done}), 0);
      @(negedge clk);
      chk("midrst_nodone", W'(n_done - snap), 0);
      rst_n = 1'b1;
      do_op(32'h0000_0001, 32'h0000_0002, 1'b0);
      chk("postrst_one_done", W'(n_done - snap), 1);

      // Random operations.
      for (int i = 0; i < 40; i++) begin
         do_op($urandom, $urandom, 1'($urandom));
      end
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      do_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);

      wait_idle();
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", W'(sb.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
